consec_seq_monitor: RTL and testbench
=====================================

// Module: consec_seq_monitor
// PURPOSE
//  Synthesizable runtime checker for the consecutive-repetition rule
//  "rose(a) |=> b[*B_REPS] ##1 c" with disable-iff semantics.
//  Sits downstream of the stimulus/DUT stage that drives a, b and c.
//  Reports pass/fail per attempt and keeps saturating tallies for on-chip debug.
//  Tracks overlapping attempts concurrently, matching SVA per-attempt evaluation.
// PARAMETERS
//  B_REPS  2  required consecutive cycles of b after the trigger (>=1)
//  CNT_W   8  width of pass/fail counters (>=2)
// PORTS
//  clock        in   1      rising-edge clock
//  reset_n      in   1      asynchronous, active-low reset
//  disable_i    in   1      synchronous abort (disable iff): kills all attempts
//  a            in   1      trigger; an attempt starts on a 0->1 transition
//  b            in   1      must hold for B_REPS cycles starting the cycle after trigger
//  c            in   1      must be high the cycle after the last b
//  busy         out  1      any attempt in flight (combinational from token vector)
//  pass         out  1      registered pulse: >=1 attempt completed OK last cycle
//  fail         out  1      registered pulse: >=1 attempt failed last cycle
//  pass_count   out  CNT_W  saturating count of passed attempts
//  fail_count   out  CNT_W  saturating count of failed attempts
//  err_sticky   out  1      sticky any-fail flag (feature-gated, see CONFIGURATION)
//  first_fail_stage out 8   stage index of first failure (feature-gated)
// BEHAVIOUR
//  - All outputs/state reset to 0 asynchronously; a_q resets to 0, so a=1 on the
//    first sampled edge after reset counts as a rise.
//  - rose = a & ~a_q; a_q <= a every edge, also while disable_i=1.
//  - Token vector t[1..N], N=B_REPS+1; t[k]=1 means an attempt is at stage k this cycle.
//  - Stage k<=B_REPS checks b; stage N checks c.
//  - Per edge, when disable_i=0:
//      t[1] <= rose; t[k] <= t[k-1] & b for k=2..N.
//      ok  = t[N] & c.
//      bad = |(t[1..B_REPS] & ~b) | (t[N] & ~c).
//      nbad = popcount of failing tokens (0..N); npass = ok (0/1).
//  - pass <= ok; fail <= (nbad!=0): one-cycle pulses on the edge after evaluation.
//  - pass_count += npass and fail_count += nbad, both saturating at 2^CNT_W-1 (no wrap).
//  - disable_i=1: t <= 0, pass <= 0, fail <= 0, counters hold, no new attempt
//    (a rise seen while disabled is lost).
//  - Overlap: a new rise while tokens are in flight starts an independent attempt.
//    One cycle can pass one attempt and fail others; pass and fail may both pulse.
//  - Latency: trigger at cycle T, b at T+1..T+B_REPS, c at T+B_REPS+1,
//    pass pulse at T+B_REPS+2.
//  - Early fail: b low at stage k pulses fail the next cycle; the attempt is dropped.
//  - busy = |t. Async reset mid-attempt drops all tokens silently; no fail is counted.
// CONFIGURATION
//  CONSEC_SEQ_MONITOR_STICKY_EN defined:
//    err_sticky is set on the first fail pulse and held until reset.
//    first_fail_stage latches the lowest failing stage index (1..N) of the first
//    failing cycle; held until reset; disable_i does not clear either output.
//  Not defined: err_sticky=0 and first_fail_stage=0 constant; no registers inferred.
// TESTING
//  1 Legal (B_REPS=2): a rises T1, b@T2,T3, c@T4 -> pass@T5, pass_count=1, fail_count=0.
//  2 Short b: a rises T1, b@T2 only -> fail@T4, fail_count=1, sticky stage=2 (EN).
//  3 Overlap: a rises T1 and T3 (0 at T2), b@T2..T5, c@T4 low, c@T6 high
//    -> fail@T5 for the first attempt, pass@T7 for the second; counts 1/1.
//  4 Disable: rise T1, b@T2, disable_i@T3 -> no pass/fail, busy=0 @T4, counters unchanged.
//  5 Saturation (CNT_W=2): 5 failing attempts -> fail_count sticks at 3.
//  6 Reset mid-attempt: reset_n low at T2 -> all outputs 0 immediately; counts 0.

Source files
------------

// File: rtl/consec_seq_monitor.sv
// Runtime checker for "rose(a) |=> b[*B_REPS] ##1 c" with disable-iff abort and overlapping attempts.
// Optional sticky error capture is enabled by defining CONSEC_SEQ_MONITOR_STICKY_EN.
module consec_seq_monitor #(
  parameter int B_REPS = 2,
  parameter int CNT_W  = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             disable_i,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  output logic             busy,
  output logic             pass,
  output logic             fail,
  output logic [CNT_W-1:0] pass_count,
  output logic [CNT_W-1:0] fail_count,
  output logic             err_sticky,
  output logic [7:0]       first_fail_stage
);

  localparam int N     = B_REPS + 1;
  localparam int NB_W  = $clog2(N + 1);
  localparam int SUM_W = ((CNT_W > NB_W) ? CNT_W : NB_W) + 1;
  localparam logic [SUM_W-1:0] CNT_MAX = {{(SUM_W-CNT_W){1'b0}}, {CNT_W{1'b1}}};

  logic            a_q;
  logic [N:1]      t;
  logic            rose;
  logic            ok;
  logic [N:1]      bad_vec;
  logic [NB_W-1:0] nbad;
  logic [SUM_W-1:0] pass_sum;
  logic [SUM_W-1:0] fail_sum;

  always_comb begin
    rose    = a & ~a_q;
    ok      = t[N] & c;
    bad_vec = '0;
    for (int k = 1; k <= B_REPS; k++) begin
      bad_vec[k] = t[k] & ~b;
    end
    bad_vec[N] = t[N] & ~c;
    nbad = '0;
    for (int k = 1; k <= N; k++) begin
      if (bad_vec[k]) nbad = nbad + NB_W'(1);
    end
    pass_sum = SUM_W'(pass_count) + SUM_W'(ok);
    fail_sum = SUM_W'(fail_count) + SUM_W'(nbad);
  end

  assign busy = |t;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      a_q        <= 1'b0;
      t          <= '0;
      pass       <= 1'b0;
      fail       <= 1'b0;
      pass_count <= '0;
      fail_count <= '0;
    end else begin
      // a_q keeps tracking while disabled so a rise during disable is consumed
      a_q <= a;
      if (disable_i) begin
        t    <= '0;
        pass <= 1'b0;
        fail <= 1'b0;
      end else begin
        t          <= {t[N-1:1] & {B_REPS{b}}, rose};
        pass       <= ok;
        fail       <= |bad_vec;
        pass_count <= (pass_sum > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : pass_sum[CNT_W-1:0];
        fail_count <= (fail_sum > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : fail_sum[CNT_W-1:0];
      end
    end
  end

`ifdef CONSEC_SEQ_MONITOR_STICKY_EN
  logic [7:0] low_stage;

  always_comb begin
    low_stage = '0;
    for (int k = N; k >= 1; k--) begin
      if (bad_vec[k]) low_stage = 8'(k);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      err_sticky       <= 1'b0;
      first_fail_stage <= '0;
    end else if (!disable_i && (|bad_vec) && !err_sticky) begin
      err_sticky       <= 1'b1;
      first_fail_stage <= low_stage;
    end
  end
`else
  assign err_sticky       = 1'b0;
  assign first_fail_stage = '0;
`endif

endmodule

// File: tb/tb_consec_seq_monitor.sv
// Scoreboard bench for consec_seq_monitor: an attempt-age model predicts outputs per cycle.
module tb_consec_seq_monitor;

  localparam int BR   = 2;
  localparam int CW   = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic          clock, reset_n, disable_i, a, b, c;
  logic          busy, pass, fail, err_sticky;
  logic [CW-1:0] pass_count, fail_count;
  logic [7:0]    first_fail_stage;

  int n_run  = 0;
  int n_fail = 0;

  // model state
  int         m_ages[$];
  logic       m_a_q;
  logic       m_pass, m_fail, m_sticky;
  int         m_pc, m_fc, m_stage;
  logic [15:0] sb[$];

  consec_seq_monitor #(.B_REPS(BR), .CNT_W(CW)) dut (
    .clock(clock), .reset_n(reset_n), .disable_i(disable_i),
    .a(a), .b(b), .c(c),
    .busy(busy), .pass(pass), .fail(fail),
    .pass_count(pass_count), .fail_count(fail_count),
    .err_sticky(err_sticky), .first_fail_stage(first_fail_stage)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] obs();
    return {pass, fail, busy, pass_count, fail_count, err_sticky, first_fail_stage};
  endfunction

  task automatic model_clear();
    m_ages.delete();
    m_a_q = 1'b0; m_pass = 1'b0; m_fail = 1'b0; m_sticky = 1'b0;
    m_pc = 0; m_fc = 0; m_stage = 0;
    sb.delete();
  endtask

  task automatic drive(input logic ia, input logic ib, input logic ic, input logic idis);
    int   keep[$];
    int   nb, np, low;
    logic st;
    logic [7:0] stg;
    a = ia; b = ib; c = ic; disable_i = idis;
    nb = 0; np = 0; low = 0;
    if (!idis) begin
      foreach (m_ages[i]) begin
        int k;
        k = m_ages[i];
        if (k <= BR) begin
          if (ib) keep.push_back(k + 1);
          else begin nb++; if (low == 0 || k < low) low = k; end
        end else begin
          if (ic) np++;
          else begin nb++; if (low == 0 || k < low) low = k; end
        end
      end
      if (ia && !m_a_q) keep.push_back(1);
      m_ages = keep;
      m_pass = (np != 0);
      m_fail = (nb != 0);
      m_pc = (m_pc + np > CMAX) ? CMAX : m_pc + np;
      m_fc = (m_fc + nb > CMAX) ? CMAX : m_fc + nb;
      if (nb != 0 && !m_sticky) begin m_sticky = 1'b1; m_stage = low; end
    end else begin
      m_ages.delete();
      m_pass = 1'b0;
      m_fail = 1'b0;
    end
    m_a_q = ia;
`ifdef CONSEC_SEQ_MONITOR_STICKY_EN
    st = m_sticky; stg = 8'(m_stage);
`else
    st = 1'b0; stg = 8'd0;
`endif
    sb.push_back({m_pass, m_fail, (m_ages.size() != 0), CW'(m_pc), CW'(m_fc), st, stg});
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; a = 1'b0; b = 1'b0; c = 1'b0; disable_i = 1'b0;
    model_clear();
    @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_run++;
    if (obs() !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_state: got %b expected %b", obs(), 16'h0);
    end
  endtask

  task automatic test_legal();
    logic [3:0] rows [6] = '{4'b0000, 4'b1000, 4'b0100, 4'b0100, 4'b0010, 4'b0000};
    logic [15:0] e;
    do_reset();
    foreach (rows[i]) begin
      drive(rows[i][3], rows[i][2], rows[i][1], rows[i][0]);
      e = sb.pop_front();
      n_run++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL legal row %0d: got %b expected %b", i, obs(), e);
      end
      if (i == 4) begin
        n_run++;
        if (pass !== 1'b1 || fail !== 1'b0) begin
          n_fail++;
          $display("FAIL legal_pulse: got pass=%b fail=%b expected pass=1 fail=0", pass, fail);
        end
      end
    end
    n_run++;
    if (pass_count !== 2'd1 || fail_count !== 2'd0) begin
      n_fail++;
      $display("FAIL legal_counts: got %0d/%0d expected 1/0", pass_count, fail_count);
    end
  endtask

  task automatic test_short_b();
    logic [3:0] rows [4] = '{4'b1000, 4'b0100, 4'b0000, 4'b0000};
    logic [15:0] e;
    do_reset();
    foreach (rows[i]) begin
      drive(rows[i][3], rows[i][2], rows[i][1], rows[i][0]);
      e = sb.pop_front();
      n_run++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL short_b row %0d: got %b expected %b", i, obs(), e);
      end
      if (i == 2) begin
        n_run++;
        if (fail !== 1'b1) begin
          n_fail++;
          $display("FAIL short_b_pulse: got fail=%b expected 1", fail);
        end
      end
    end
    n_run++;
    if (fail_count !== 2'd1 || pass_count !== 2'd0) begin
      n_fail++;
      $display("FAIL short_b_counts: got %0d/%0d expected 0/1", pass_count, fail_count);
    end
`ifdef CONSEC_SEQ_MONITOR_STICKY_EN
    n_run++;
    if (err_sticky !== 1'b1 || first_fail_stage !== 8'd2) begin
      n_fail++;
      $display("FAIL short_b_sticky: got %b/%0d expected 1/2", err_sticky, first_fail_stage);
    end
`endif
  endtask

  task automatic test_overlap();
    logic [3:0] rows [7] = '{4'b1000, 4'b0100, 4'b1100, 4'b0100, 4'b0100, 4'b0010, 4'b0000};
    logic [15:0] e;
    do_reset();
    foreach (rows[i]) begin
      drive(rows[i][3], rows[i][2], rows[i][1], rows[i][0]);
      e = sb.pop_front();
      n_run++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL overlap row %0d: got %b expected %b", i, obs(), e);
      end
      if (i == 3 || i == 5) begin
        n_run++;
        if ({pass, fail} !== ((i == 3) ? 2'b01 : 2'b10)) begin
          n_fail++;
          $display("FAIL overlap_pulse row %0d: got pass/fail=%b%b", i, pass, fail);
        end
      end
    end
    n_run++;
    if (pass_count !== 2'd1 || fail_count !== 2'd1) begin
      n_fail++;
      $display("FAIL overlap_counts: got %0d/%0d expected 1/1", pass_count, fail_count);
    end
  endtask

  // runs straight after test_overlap so the 1/1 counts must survive the disable
  task automatic test_disable();
    logic [3:0] rows [7] = '{4'b1000, 4'b0100, 4'b0101, 4'b0001, 4'b1001, 4'b1000, 4'b1100};
    logic [15:0] e;
    foreach (rows[i]) begin
      drive(rows[i][3], rows[i][2], rows[i][1], rows[i][0]);
      e = sb.pop_front();
      n_run++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL disable row %0d: got %b expected %b", i, obs(), e);
      end
      if (i == 2 || i == 6) begin
        n_run++;
        if ({busy, pass, fail} !== 3'b000) begin
          n_fail++;
          $display("FAIL disable_quiet row %0d: got busy/pass/fail=%b%b%b expected 000", i, busy, pass, fail);
        end
      end
    end
    n_run++;
    if (pass_count !== 2'd1 || fail_count !== 2'd1) begin
      n_fail++;
      $display("FAIL disable_counts: got %0d/%0d expected 1/1", pass_count, fail_count);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    void'(sb.pop_front());
  endtask

  task automatic test_back_to_back();
    logic [3:0] rows [9] = '{4'b1000, 4'b0100, 4'b1100, 4'b0010, 4'b0000,
                             4'b1000, 4'b0100, 4'b1100, 4'b0000};
    logic [15:0] e;
    do_reset();
    foreach (rows[i]) begin
      drive(rows[i][3], rows[i][2], rows[i][1], rows[i][0]);
      e = sb.pop_front();
      n_run++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL back_to_back row %0d: got %b expected %b", i, obs(), e);
      end
      if (i == 3) begin
        n_run++;
        if ({pass, fail} !== 2'b11) begin
          n_fail++;
          $display("FAIL b2b_both_pulse: got pass/fail=%b%b expected 11", pass, fail);
        end
      end
    end
    n_run++;
    if (fail_count !== 2'd3 || pass_count !== 2'd1) begin
      n_fail++;
      $display("FAIL b2b_counts: got %0d/%0d expected 1/3", pass_count, fail_count);
    end
`ifdef CONSEC_SEQ_MONITOR_STICKY_EN
    n_run++;
    if (first_fail_stage !== 8'd1) begin
      n_fail++;
      $display("FAIL b2b_stage: got %0d expected 1", first_fail_stage);
    end
`endif
  endtask

  task automatic test_saturation();
    logic [15:0] e;
    do_reset();
    for (int n = 0; n < 5; n++) begin
      for (int r = 0; r < 2; r++) begin
        drive(r == 0, 1'b0, 1'b0, 1'b0);
        e = sb.pop_front();
        n_run++;
        if (obs() !== e) begin
          n_fail++;
          $display("FAIL saturation attempt %0d row %0d: got %b expected %b", n, r, obs(), e);
        end
      end
    end
    n_run++;
    if (fail_count !== 2'd3) begin
      n_fail++;
      $display("FAIL saturation_count: got %0d expected 3", fail_count);
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] rows [6] = '{4'b1000, 4'b0100, 4'b0100, 4'b0010, 4'b0000, 4'b1000};
    logic [15:0] e;
    do_reset();
    foreach (rows[i]) begin
      drive(rows[i][3], rows[i][2], rows[i][1], rows[i][0]);
      e = sb.pop_front();
      n_run++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL reset_mid row %0d: got %b expected %b", i, obs(), e);
      end
    end
    b = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    n_run++;
    if (obs() !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_mid_async: got %b expected %b", obs(), 16'h0);
    end
    model_clear();
    a = 1'b0; b = 1'b0;
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      e = sb.pop_front();
      n_run++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL reset_mid_after row %0d: got %b expected %b", i, obs(), e);
      end
    end
  endtask

  initial begin
    reset_n = 1'b0; disable_i = 1'b0; a = 1'b0; b = 1'b0; c = 1'b0;
    model_clear();
    #12;
    test_reset();
    test_legal();
    test_short_b();
    test_overlap();
    test_disable();
    test_back_to_back();
    test_saturation();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
